// File: rtl/regbus_arbiter.sv
// -----------------------------------------------------------------------------
// regbus_arbiter
//   Round-robin arbiter and sequencer for the single register-access bus of the
//   register-file top. It serialises NREQ requesters, performs exactly one bus
//   access per grant, returns read data and pulses a per-requester completion.
//
// Ports
//   CLK         clock, all logic on the rising edge
//   RST         asynchronous active-low reset
//   REQ         per-requester request level
//   REQ_WR      per-requester direction (1 = write, 0 = read)
//   REQ_ADDR    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   REQ_WDATA   packed write data, requester i at [i*DATA_W +: DATA_W]
//   GNT         one-hot grant, held for the whole transaction
//   DONE        one-hot, single-cycle completion pulse
//   RDATA       data of the last completed read
//   WRITE/READ  single-cycle bus strobes
//   ADDR        bus address
//   WRITE_DATA  bus write data
//   READ_DATA   bus read data, valid READ_LAT cycles after the READ strobe
// -----------------------------------------------------------------------------
module regbus_arbiter #(
  parameter int NREQ     = 4,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 2,
  parameter int READ_LAT = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          REQ,
  input  logic [NREQ-1:0]          REQ_WR,
  input  logic [NREQ*ADDR_W-1:0]   REQ_ADDR,
  input  logic [NREQ*DATA_W-1:0]   REQ_WDATA,
  output logic [NREQ-1:0]          GNT,
  output logic [NREQ-1:0]          DONE,
  output logic [DATA_W-1:0]        RDATA,
  output logic                     WRITE,
  output logic                     READ,
  output logic [ADDR_W-1:0]        ADDR,
  output logic [DATA_W-1:0]        WRITE_DATA,
  input  logic [DATA_W-1:0]        READ_DATA
);

  localparam int PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (READ_LAT > 2) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_FIN} state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr;        // last requester served
  logic [PTR_W-1:0]    gnt_idx;    // requester currently granted
  logic [PTR_W-1:0]    sel;        // arbitration winner this cycle
  logic                found;
  logic                pick_wr;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic                lat_wr;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [CNT_W-1:0]    cnt;        // remaining WAIT cycles minus one

  // Round-robin search: first pass covers requesters above the pointer, the
  // second pass wraps around to 0..ptr, so the last-served requester comes last.
  // NOTE: every signal driven in always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i > int'(ptr)) && REQ[i]) begin
        found = 1'b1;
        sel   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && (i <= int'(ptr)) && REQ[i]) begin
        found = 1'b1;
        sel   = PTR_W'(i);
      end
    end
  end

  // Demultiplex the winner's request fields.
  always_comb begin
    pick_wr    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(sel) == i) begin
        pick_wr    = REQ_WR[i];
        pick_addr  = REQ_ADDR[i*ADDR_W +: ADDR_W];
        pick_wdata = REQ_WDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (found) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = lat_wr ? ST_FIN : ST_WAIT;
      ST_WAIT:  if (cnt == '0) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr       <= PTR_W'(NREQ - 1);
      gnt_idx   <= '0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      RDATA     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            gnt_idx   <= sel;
            lat_wr    <= pick_wr;
            lat_addr  <= pick_addr;
            lat_wdata <= pick_wdata;
          end
        end
        ST_ISSUE: begin
          if (!lat_wr) cnt <= CNT_W'(READ_LAT - 1);
        end
        ST_WAIT: begin
          // The edge that ends the last WAIT cycle is the one that sees valid data.
          if (cnt == '0) RDATA <= READ_DATA;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_FIN: ptr <= gnt_idx;
        default: ;
      endcase
    end
  end

  // Outputs are decoded from registered state only, so reset clears them at once.
  always_comb begin
    GNT        = '0;
    DONE       = '0;
    WRITE      = 1'b0;
    READ       = 1'b0;
    ADDR       = '0;
    WRITE_DATA = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state != ST_IDLE) && (int'(gnt_idx) == i)) GNT[i] = 1'b1;
    end
    if (state != ST_IDLE) ADDR = lat_addr;
    if (state == ST_ISSUE) begin
      WRITE = lat_wr;
      READ  = !lat_wr;
      if (lat_wr) WRITE_DATA = lat_wdata;
    end
    if (state == ST_FIN) DONE = GNT;
  end

endmodule

// File: tb/tb_regbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regbus_arbiter
//   Self-checking bench for regbus_arbiter. A transaction-level reference model
//   (round-robin pointer, register contents, last read value) predicts each
//   grant's cycle-by-cycle outputs; a small register-file model answers bus
//   reads READ_LAT cycles after the strobe and returns noise otherwise.
// -----------------------------------------------------------------------------
module tb_regbus_arbiter;

  localparam int NREQ     = 4;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 2;
  localparam int READ_LAT = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ-1:0]        req_wr;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt, done;
  logic [DATA_W-1:0]      rdata;
  logic                   write, read;
  logic [ADDR_W-1:0]      addr;
  logic [DATA_W-1:0]      write_data;
  logic [DATA_W-1:0]      read_data = '0;

  // Per-requester stimulus fields, packed onto the DUT buses below.
  logic                   r_wr    [NREQ];
  logic [ADDR_W-1:0]      r_addr  [NREQ];
  logic [DATA_W-1:0]      r_wdata [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign req_wr[i]                      = r_wr[i];
    assign req_addr[i*ADDR_W +: ADDR_W]   = r_addr[i];
    assign req_wdata[i*DATA_W +: DATA_W]  = r_wdata[i];
  end

  regbus_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)
  ) dut (
    .CLK(clk), .RST(rst), .REQ(req), .REQ_WR(req_wr), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .GNT(gnt), .DONE(done), .RDATA(rdata),
    .WRITE(write), .READ(read), .ADDR(addr), .WRITE_DATA(write_data),
    .READ_DATA(read_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int                ref_ptr;
  logic [DATA_W-1:0] ref_rdata;
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];

  // Register-file (bus slave) model.
  logic [DATA_W-1:0] bus_mem [2**ADDR_W];
  logic              pv [READ_LAT];
  logic [DATA_W-1:0] pd [READ_LAT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called just after the mid-cycle checks; advances to 1 time unit after the
  // next rising edge, applying the bus access the DUT presented this cycle.
  task automatic tick();
    logic w, r;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    w = write; r = read; a = addr; wd = write_data;
    @(posedge clk); #1;
    for (int i = READ_LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = r;
    pd[0] = bus_mem[a];
    if (w) bus_mem[a] = wd;
    read_data = pv[READ_LAT-1] ? pd[READ_LAT-1] : DATA_W'($urandom);
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < READ_LAT; i++) pv[i] = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},   32'(gnt),        32'(0));
    check({tag, "_done"},  32'(done),       32'(0));
    check({tag, "_write"}, 32'(write),      32'(0));
    check({tag, "_read"},  32'(read),       32'(0));
    check({tag, "_addr"},  32'(addr),       32'(0));
    check({tag, "_wdata"}, 32'(write_data), 32'(0));
    check({tag, "_rdata"}, 32'(rdata),      32'(ref_rdata));
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases it.
  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    ref_rdata = '0;
    #1;
    check_quiet("rst");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    ref_ptr = NREQ - 1;
    clear_pipe();
  endtask

  task automatic idle_cycle();
    req = '0;
    @(negedge clk);
    check_quiet("idle");
    tick();
  endtask

  // One complete grant, starting in a cycle where the DUT is idle and REQ is
  // already applied. req_after is applied two cycles later; scramble changes
  // every requester's fields while the transaction is in flight.
  task automatic run_txn(input logic [NREQ-1:0] req_after, input bit scramble);
    int g;
    logic wr;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [NREQ-1:0] oh;
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (g < 0 && req[(ref_ptr + k) % NREQ]) g = (ref_ptr + k) % NREQ;
    end
    wr = r_wr[g]; a = r_addr[g]; d = r_wdata[g];
    oh = '0; oh[g] = 1'b1;

    @(negedge clk);
    check_quiet("arb");
    tick();
    if (scramble) begin
      for (int i = 0; i < NREQ; i++) begin
        r_wr[i]    = 1'($urandom);
        r_addr[i]  = ADDR_W'($urandom);
        r_wdata[i] = DATA_W'($urandom);
      end
    end

    @(negedge clk);
    check("iss_gnt",   32'(gnt),        32'(oh));
    check("iss_done",  32'(done),       32'(0));
    check("iss_write", 32'(write),      32'(wr));
    check("iss_read",  32'(read),       32'(!wr));
    check("iss_addr",  32'(addr),       32'(a));
    check("iss_wdata", 32'(write_data), wr ? 32'(d) : 32'(0));
    tick();
    req = req_after;

    if (!wr) begin
      for (int c = 0; c < READ_LAT; c++) begin
        @(negedge clk);
        check("wait_gnt",   32'(gnt),   32'(oh));
        check("wait_done",  32'(done),  32'(0));
        check("wait_write", 32'(write), 32'(0));
        check("wait_read",  32'(read),  32'(0));
        check("wait_addr",  32'(addr),  32'(a));
        tick();
      end
    end

    if (wr) ref_mem[a] = d;
    else    ref_rdata  = ref_mem[a];
    ref_ptr = g;
    @(negedge clk);
    check("fin_gnt",   32'(gnt),   32'(oh));
    check("fin_done",  32'(done),  32'(oh));
    check("fin_write", 32'(write), 32'(0));
    check("fin_read",  32'(read),  32'(0));
    check("fin_rdata", 32'(rdata), 32'(ref_rdata));
    tick();
  endtask

  task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    r_wr[i] = wr; r_addr[i] = a; r_wdata[i] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      ref_mem[i] = DATA_W'($urandom);
      bus_mem[i] = ref_mem[i];
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
    clear_pipe();
    ref_rdata = '0;
    ref_ptr   = NREQ - 1;

    #1;
    do_reset();

    // Single write by requester 0, then a read of the same register by 2.
    set_req(0, 1'b1, 3'd0, 2'b10);
    req = 4'b0001;
    run_txn(4'b0000, 1'b0);
    set_req(2, 1'b0, 3'd0, 2'b00);
    req = 4'b0100;
    run_txn(4'b0000, 1'b0);
    check("read_value", 32'(rdata), 32'(2'b10));
    idle_cycle();
    idle_cycle();

    // Reset while the read is waiting for data.
    req = 4'b0100;
    @(negedge clk); tick();
    @(negedge clk); tick();
    @(negedge clk);
    check("pre_rst_gnt", 32'(gnt), 32'(4'b0100));
    #2;
    do_reset();
    set_req(1, 1'b1, 3'd5, 2'b01);
    req = 4'b0010;
    run_txn(4'b0000, 1'b0);

    // Full contention, all writes: order 0,1,2,3,0 after reset.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, ADDR_W'(i + 1), DATA_W'(i));
    req = 4'b1111;
    for (int t = 0; t < 5; t++) run_txn(4'b1111, 1'b0);
    check("contention_ptr_end", 32'(ref_ptr), 32'(0));

    // Hog on requester 1; requester 3 raised while 1 is in flight.
    idle_cycle();
    req = 4'b0010;
    run_txn(4'b1010, 1'b0);
    run_txn(4'b0010, 1'b0);
    run_txn(4'b0000, 1'b0);

    // Requester 0 withdraws its request right after the grant.
    set_req(0, 1'b1, 3'd7, 2'b11);
    req = 4'b0001;
    run_txn(4'b0000, 1'b0);

    // Randomised traffic.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_cycle();
      end else begin
        for (int i = 0; i < NREQ; i++)
          set_req(i, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
        req = NREQ'($urandom_range(1, 2**NREQ - 1));
        run_txn(NREQ'($urandom), 1'($urandom));
      end
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regbus_arbiter.md
Name: regbus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single register-access bus (WRITE/READ/ADDR/WRITE_DATA/READ_DATA) of the register-file top among NREQ requesters.
- Serialises requests, drives exactly one bus access per grant, returns read data, and signals completion per requester.
- Sits between requester blocks and the register-file module in the same clock domain.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 3, register address width
- DATA_W, 2, register data width
- READ_LAT, 1, cycles from READ strobe to valid READ_DATA (1..4)

Ports:
- CLK  input  1  clock; all logic on the rising edge
- RST  input  1  asynchronous, active-low reset
- REQ  input  NREQ  per-requester request level
- REQ_WR  input  NREQ  per-requester: 1 = write, 0 = read
- REQ_ADDR  input  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- REQ_WDATA  input  NREQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
- GNT  output  NREQ  one-hot grant, held for the whole transaction
- DONE  output  NREQ  one-hot, one-cycle completion pulse
- RDATA  output  DATA_W  data of the last completed read
- WRITE  output  1  bus write strobe
- READ  output  1  bus read strobe
- ADDR  output  ADDR_W  bus address
- WRITE_DATA  output  DATA_W  bus write data
- READ_DATA  input  DATA_W  bus read data

Behaviour:
- Reset (RST=0, asynchronous):
  - GNT, DONE, WRITE, READ, ADDR, WRITE_DATA and RDATA all go to 0.
  - FSM goes to IDLE.
  - The round-robin pointer resets to NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, FIN.
- IDLE:
  - If any REQ bit is set, select the first set bit searching upward from pointer+1, wrapping modulo NREQ.
  - Register GNT one-hot and latch that requester's REQ_WR, REQ_ADDR and REQ_WDATA.
  - Next state is ISSUE.
  - If no REQ bit is set, stay in IDLE with all outputs 0 except RDATA.
- ISSUE (exactly 1 cycle):
  - ADDR is the latched address.
  - For a write: WRITE=1 and WRITE_DATA is the latched data. Next state is FIN.
  - For a read: READ=1 and WRITE_DATA=0. Next state is WAIT.
- WAIT (exactly READ_LAT cycles, counted by a down-counter):
  - WRITE=0, READ=0, ADDR held.
  - On the rising edge that ends the last WAIT cycle, capture READ_DATA into RDATA.
  - Next state is FIN.
- FIN (1 cycle):
  - DONE[g]=1 for the granted requester g; GNT still asserted.
  - pointer <= g.
  - On the next edge GNT clears and the FSM returns to IDLE.
- Latency (IDLE samples REQ in cycle n):
  - Write: GNT+WRITE in cycle n+1, DONE in n+2.
  - Read: READ in n+1, DONE in n+2+READ_LAT.
  - Back-to-back throughput: one write per 3 cycles; one read per 3+READ_LAT cycles.
- Request handling:
  - Requests are sampled only in IDLE.
  - Requester inputs are latched at grant; later changes, including REQ dropping, do not affect the transaction in flight.
  - A requester must drop REQ in the cycle after DONE, or it re-enters arbitration.
- Arbitration:
  - Simultaneous requests are resolved purely by the round-robin pointer.
  - A requester that keeps REQ high cannot starve others: after its DONE it has the lowest priority.
- RDATA: updated only on read completion; held through writes and idle.
- Bus strobes: WRITE and READ are never both 1, and each is never high for more than 1 cycle per grant.
- Reset mid-transaction: aborts immediately, no DONE pulse, outputs forced to reset values; a bus strobe already issued is not retracted.

Test Plan:
- Single write: REQ=0001, REQ_WR[0]=1, addr0=3'd0, wdata0=2'b10 → GNT=0001 with WRITE=1, ADDR=0, WRITE_DATA=2'b10 one cycle later; DONE=0001 the cycle after that; then all outputs 0.
- Read, READ_LAT=1: requester 2 reads addr 0 after the write above, with the bench model returning 2'b10 one cycle after READ → READ pulses 1 cycle; DONE=0100 at n+3; RDATA=2'b10 and held afterwards.
- Contention: REQ=1111 held constantly, all writes → grant order 0,1,2,3,0; each DONE 3 cycles apart; GNT always one-hot.
- Fairness under a hog: REQ[1] held constantly and REQ[3] raised once → requester 3 is granted immediately after requester 1's current DONE, not after a second grant to 1.
- Request withdrawn: requester 0 drops REQ the cycle after GNT → the write still completes and DONE=0001 pulses.
- Async reset: RST=0 asserted during WAIT with READ_LAT=4 → GNT, READ and DONE are 0 before the next edge and RDATA=0; after release, REQ=0010 grants requester 1 normally.
